// File: rtl/cruise_throttle_ctrl.sv
// ---------------------------------------------------------------------------
// cruise_throttle_ctrl
//
// Cruise-control throttle sequencer. After an engage request it loads an
// initial throttle value. From then on it nudges the throttle up or down by
// STEP whenever the speed comparator flags settle on "below" or "above" set
// speed. It holds the throttle when the flags settle on "equal". Brake, or
// dropping the engage request, returns the block to IDLE with zero throttle.
//
// Build option:
//   FLAG_FILTER_EN  defined   : a flag vector must be seen unchanged on
//                               SETTLE_CYC consecutive edges before it acts.
//                   undefined : every valid flag vector acts immediately, and
//                               no filter counter is built.
//
// Parameters:
//   STEP        throttle change per qualified action
//   SETTLE_CYC  consecutive identical samples needed to qualify (>= 1)
//   THR_MAX     upper throttle limit
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        engage request (level)
//   brake     brake pedal (level), overrides everything
//   thr_init  throttle loaded on engage
//   G/Eq/L    speed above / equal / below set speed
//   throttle  registered throttle command
//   state     IDLE=0, CRUISE=1, ACCEL=2, DECEL=3
//   active    high outside IDLE
//   sat       one-cycle pulse when an action is clipped at 0 or THR_MAX
//   fault     high while the last sampled flag vector is not one-hot
// ---------------------------------------------------------------------------
module cruise_throttle_ctrl #(
  parameter int unsigned STEP       = 4,
  parameter int unsigned SETTLE_CYC = 3,
  parameter logic [7:0]  THR_MAX    = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       brake,
  input  logic [7:0] thr_init,
  input  logic       G,
  input  logic       Eq,
  input  logic       L,
  output logic [7:0] throttle,
  output logic [1:0] state,
  output logic       active,
  output logic       sat,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CRUISE = 2'd1,
    ACCEL  = 2'd2,
    DECEL  = 2'd3
  } state_t;

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] MAX9  = {1'b0, THR_MAX};

  state_t     state_q, state_d;
  logic [7:0] thr_q, thr_d;
  logic       sat_q, sat_d;
  logic       fault_q, fault_d;

  logic [2:0] flags;
  logic       valid;
  logic       release_req;
  logic       live;
  logic       qual;

  logic [8:0] sum9, dif9;
  logic       up_clip, up_sat, under, dn_sat;
  logic [7:0] up_val, dn_val, init_val;

  assign flags       = {G, Eq, L};
  assign valid       = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign release_req = brake || !en;
  // Flags are only looked at while engaged and not being released this edge.
  assign live        = !release_req && (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Flag qualification
  // ---------------------------------------------------------------------
`ifdef FLAG_FILTER_EN
  localparam int unsigned    CW       = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0]  SETTLE_N = CW'(SETTLE_CYC);

  logic [CW-1:0] cnt_q, cnt_d, run_cnt;
  logic [2:0]    prev_q, prev_d;

  // Length of the identical-vector run including this edge; cnt_q==0 means
  // the run was restarted, so the stored previous vector must not extend it.
  assign run_cnt = ((cnt_q != '0) && (flags == prev_q)) ? cnt_q + CW'(1) : CW'(1);
  assign qual    = (run_cnt >= SETTLE_N);

  always_comb begin
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (!live || !valid) begin
      cnt_d = '0;
    end else begin
      prev_d = flags;
      cnt_d  = qual ? '0 : run_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end
`else
  assign qual = 1'b1;

  // SETTLE_CYC has no role without the filter; referenced only so the
  // parameter list stays identical across both builds.
  logic unused_settle;
  assign unused_settle = ^SETTLE_CYC;
`endif

  // ---------------------------------------------------------------------
  // Throttle arithmetic (9-bit so carry/borrow are visible)
  // ---------------------------------------------------------------------
  assign sum9    = {1'b0, thr_q} + STEP9;
  assign up_clip = (sum9 > MAX9);
  assign up_val  = up_clip ? THR_MAX : sum9[7:0];
  // A clip that leaves the throttle where it already was is not reported.
  assign up_sat  = up_clip && (up_val != thr_q);

  assign dif9    = {1'b0, thr_q} - STEP9;
  assign under   = dif9[8];
  assign dn_val  = under ? '0 : dif9[7:0];
  assign dn_sat  = under && (thr_q != '0);

  assign init_val = (thr_init > THR_MAX) ? THR_MAX : thr_init;

  // ---------------------------------------------------------------------
  // FSM next state / outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    sat_d   = 1'b0;
    fault_d = fault_q;

    if (release_req) begin
      state_d = IDLE;
      thr_d   = '0;
      fault_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = CRUISE;
      thr_d   = init_val;
      fault_d = 1'b0;
    end else if (!valid) begin
      fault_d = 1'b1;
    end else begin
      fault_d = 1'b0;
      if (qual) begin
        if (L) begin
          state_d = ACCEL;
          thr_d   = up_val;
          sat_d   = up_sat;
        end else if (G) begin
          state_d = DECEL;
          thr_d   = dn_val;
          sat_d   = dn_sat;
        end else begin
          state_d = CRUISE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      thr_q   <= '0;
      sat_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      sat_q   <= sat_d;
      fault_q <= fault_d;
    end
  end

  assign throttle = thr_q;
  assign state    = state_q;
  assign active   = (state_q != IDLE);
  assign sat      = sat_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_cruise_throttle_ctrl.sv
module tb_cruise_throttle_ctrl;

  localparam int STEP    = 4;
  localparam int SETTLE  = 3;
  localparam int THR_MAX = 200;
`ifdef FLAG_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  localparam logic [2:0] VL = 3'b001;
  localparam logic [2:0] VE = 3'b010;
  localparam logic [2:0] VG = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       brake = 1'b0;
  logic [7:0] thr_init = 8'd0;
  logic       G = 1'b0;
  logic       Eq = 1'b0;
  logic       L = 1'b0;
  logic [7:0] throttle;
  logic [1:0] state;
  logic       active;
  logic       sat;
  logic       fault;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cruise_throttle_ctrl #(
    .STEP(4),
    .SETTLE_CYC(3),
    .THR_MAX(8'd200)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .brake(brake),
    .thr_init(thr_init),
    .G(G),
    .Eq(Eq),
    .L(L),
    .throttle(throttle),
    .state(state),
    .active(active),
    .sat(sat),
    .fault(fault)
  );

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Behavioural model: a history of samples since the last restart; an
  // action fires when the newest SETTLE samples are all the same vector.
  int         m_state = 0;
  int         m_thr = 0;
  bit         m_sat = 1'b0;
  bit         m_fault = 1'b0;
  logic [2:0] hist[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [2:0] fv;
    bit         q;
    int         want;
    int         got;
    if (!rst_n) begin
      m_state = 0; m_thr = 0; m_sat = 1'b0; m_fault = 1'b0;
      hist.delete();
    end else begin
      fv = {G, Eq, L};
      m_sat = 1'b0;
      if (brake || !en) begin
        m_state = 0; m_thr = 0; m_fault = 1'b0;
        hist.delete();
      end else if (m_state == 0) begin
        m_state = 1;
        m_thr = (int'(thr_init) > THR_MAX) ? THR_MAX : int'(thr_init);
        m_fault = 1'b0;
        hist.delete();
      end else if ($countones(fv) != 1) begin
        m_fault = 1'b1;
        hist.delete();
      end else begin
        m_fault = 1'b0;
        hist.push_back(fv);
        if (hist.size() > SETTLE) void'(hist.pop_front());
        q = 1'b1;
        if (FILT) begin
          if (hist.size() < SETTLE) q = 1'b0;
          else for (int i = 0; i < SETTLE; i++) if (hist[i] != fv) q = 1'b0;
        end
        if (q) begin
          hist.delete();
          if (fv == VL) begin
            want = m_thr + STEP;
            got = (want > THR_MAX) ? THR_MAX : want;
            m_sat = (got != want) && (got != m_thr);
            m_thr = got; m_state = 2;
          end else if (fv == VG) begin
            want = m_thr - STEP;
            got = (want < 0) ? 0 : want;
            m_sat = (got != want) && (got != m_thr);
            m_thr = got; m_state = 3;
          end else begin
            m_state = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    pin("throttle", throttle, m_thr);
    pin("state", state, m_state);
    pin("active", active, m_state != 0);
    pin("sat", sat, m_sat);
    pin("fault", fault, m_fault);
  end

  task automatic drive(input logic e, input logic b, input logic [7:0] ini, input logic [2:0] f);
    en = e; brake = b; thr_init = ini; {G, Eq, L} = f;
    @(negedge clk);
  endtask

  task automatic engage(input logic [7:0] ini);
    drive(1'b0, 1'b0, 8'd0, VL);
    drive(1'b1, 1'b0, ini, VL);
  endtask

  logic [2:0] ftab[8] = '{VL, VL, VL, VG, VG, VE, 3'b110, 3'b000};

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    pin("rst_throttle", throttle, 0);
    pin("rst_state", state, 0);
    pin("rst_active", active, 0);
    pin("rst_sat", sat, 0);
    pin("rst_fault", fault, 0);
    rst_n = 1'b1;

    // Engage at 100, then L steady
    drive(1'b1, 1'b0, 8'd100, VL);
    pin("eng_thr", throttle, 100);
    pin("eng_state", state, 1);
    drive(1'b1, 1'b0, 8'd100, VL);
    pin("ramp_e1", throttle, FILT ? 100 : 104);
    pin("mdl_ramp_e1", m_thr, FILT ? 100 : 104);
    drive(1'b1, 1'b0, 8'd100, VL);
    drive(1'b1, 1'b0, 8'd100, VL);
    pin("ramp_e3", throttle, FILT ? 104 : 112);
    pin("ramp_e3_state", state, 2);
    repeat (3) drive(1'b1, 1'b0, 8'd100, VL);
    pin("ramp_e6", throttle, FILT ? 108 : 124);
    pin("mdl_ramp_e6", m_thr, FILT ? 108 : 124);

    // Saturation at THR_MAX
    engage(8'd198);
    repeat (3) drive(1'b1, 1'b0, 8'd198, VL);
    pin("sat_thr", throttle, 200);
    pin("sat_pulse", sat, FILT ? 1 : 0);
    drive(1'b1, 1'b0, 8'd198, VL);
    pin("sat_gone", sat, 0);
    repeat (2) drive(1'b1, 1'b0, 8'd198, VL);
    pin("sat_hold_thr", throttle, 200);
    pin("sat_hold_nopulse", sat, 0);

    // Underflow at 0
    engage(8'd2);
    repeat (3) drive(1'b1, 1'b0, 8'd2, VG);
    pin("udf_thr", throttle, 0);
    pin("udf_sat", sat, FILT ? 1 : 0);
    pin("udf_state", state, 3);

    // Chatter then fault
    engage(8'd100);
    drive(1'b1, 1'b0, 8'd100, VL);
    drive(1'b1, 1'b0, 8'd100, VL);
    drive(1'b1, 1'b0, 8'd100, VG);
    drive(1'b1, 1'b0, 8'd100, VG);
    pin("chat_e4", throttle, 100);
    drive(1'b1, 1'b0, 8'd100, VG);
    pin("chat_e5", throttle, 96);
    pin("mdl_chat_e5", m_thr, 96);
    drive(1'b1, 1'b0, 8'd100, 3'b110);
    pin("flt_set", fault, 1);
    pin("flt_thr_hold", throttle, 96);
    drive(1'b1, 1'b0, 8'd100, VE);
    pin("flt_clear", fault, 0);
    pin("flt_thr_after", throttle, 96);

    // Brake on the qualifying edge
    drive(1'b1, 1'b0, 8'd100, VL);
    drive(1'b1, 1'b0, 8'd100, VL);
    drive(1'b1, 1'b1, 8'd100, VL);
    pin("brk_state", state, 0);
    pin("brk_thr", throttle, 0);
    pin("brk_active", active, 0);
    drive(1'b1, 1'b1, 8'd100, VL);
    pin("brk_blocks_engage", state, 0);
    drive(1'b0, 1'b0, 8'd100, 3'b111);
    pin("idle_no_fault", fault, 0);

    // Engage clamp
    drive(1'b1, 1'b0, 8'd250, VE);
    pin("clamp_init", throttle, 200);

    // Reset mid-ramp
    engage(8'd50);
    repeat (3) drive(1'b1, 1'b0, 8'd50, VL);
    pin("pre_rst_thr", throttle, FILT ? 54 : 62);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    pin("midrst_thr", throttle, 0);
    pin("midrst_state", state, 0);
    pin("midrst_active", active, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'd60, VL);
    pin("reeng_state", state, 1);
    pin("reeng_thr", throttle, 60);

    // Mixed traffic, checked against the model every cycle
    for (int k = 0; k < 120; k++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 24) == 0),
            8'($urandom_range(0, 255)), ftab[$urandom_range(0, 7)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
